// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and filters the pin pair, deserialises host-receive frames
// and folds E0/F0 prefixes into toggle-announced 11-bit key events.
module ps2_key_rx #(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 25000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        key_stb,
   output logic        frame_err
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d, filt_d1_q;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fall;

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          ext_q, ext_d, rel_q, rel_d;
   logic [10:0]   key_q, key_d;
   logic          stb_q, stb_d, err_q, err_d;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         dat_s1_q  <= 1'b1;
         dat_s2_q  <= 1'b1;
         filt_q    <= 1'b1;
         filt_d1_q <= 1'b1;
         fcnt_q    <= '0;
         state_q   <= StIdle;
         cnt_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tcnt_q    <= '0;
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
         key_q     <= '0;
         stb_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         clk_s1_q  <= ps2_clk;
         clk_s2_q  <= clk_s1_q;
         dat_s1_q  <= ps2_data;
         dat_s2_q  <= dat_s1_q;
         filt_q    <= filt_d;
         filt_d1_q <= filt_q;
         fcnt_q    <= fcnt_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tcnt_q    <= tcnt_d;
         ext_q     <= ext_d;
         rel_q     <= rel_d;
         key_q     <= key_d;
         stb_q     <= stb_d;
         err_q     <= err_d;
      end
   end

   // Count consecutive samples that disagree with the filtered level; any agreeing sample restarts.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
         else                               fcnt_d = fcnt_q + 1'b1;
      end
   end

   assign fall = filt_d1_q & ~filt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      ext_d   = ext_q;
      rel_d   = rel_q;
      key_d   = key_q;
      stb_d   = 1'b0;
      err_d   = 1'b0;

      if (state_q == StIdle || fall) tcnt_d = '0;
      else                           tcnt_d = tcnt_q + 1'b1;

      if (fall) begin
         unique case (state_q)
            StIdle: begin
               if (!dat_s2_q) begin
                  state_d = StData;
                  cnt_d   = '0;
               end
            end
            StData: begin
               shift_d = {dat_s2_q, shift_q[7:1]};
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == 3'd7) state_d = StParity;
            end
            StParity: begin
               par_d   = dat_s2_q;
               state_d = StStop;
            end
            StStop: begin
               state_d = StIdle;
               ext_d   = 1'b0;
               rel_d   = 1'b0;
               if (dat_s2_q && (^{shift_q, par_q})) begin
                  case (shift_q)
                     8'hE0: begin
                        ext_d = 1'b1;
                        rel_d = rel_q;
                     end
                     8'hF0: begin
                        rel_d = 1'b1;
                        ext_d = ext_q;
                     end
                     8'hE1, 8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                     default: begin
                        key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                        stb_d = 1'b1;
                     end
                  endcase
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end else if (state_q != StIdle && tcnt_q == TW'(TIMEOUT - 1)) begin
         state_d = StIdle;
         err_d   = 1'b1;
         ext_d   = 1'b0;
         rel_d   = 1'b0;
      end
   end

   assign ps2_key   = key_q;
   assign key_stb   = stb_q;
   assign frame_err = err_q;

endmodule
